// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit: op and FSM encodings
// plus width-generic two's-complement negate/abs.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

  // Wide enough for a 2*64-bit product; callers keep the low bits they need.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic en);
    return en ? (~v + MAX_W'(1)) : v;
  endfunction

  // Magnitude of a w-bit value held zero-extended in v; sgn selects signed interpretation.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input int unsigned w,
                                             input logic sgn);
    return neg_if(v, sgn & v[w-1]);
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle on magnitudes,
// sign fix-up in a single extra cycle, result held until the consumer takes it.
module mdu_alu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MDUControl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] MDUResult,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q;
  logic [XLEN-1:0] b_q, hi_q, lo_q, res_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;

  // ---- request decode ----
  mdu_op_t         op_in;
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign op_in  = mdu_op_t'(MDUControl);
  assign is_div = MDUControl[2];
  assign a_sgn  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg  = a_sgn & SrcA[XLEN-1];
  assign b_neg  = b_sgn & SrcB[XLEN-1];
  assign a_mag  = XLEN'(abs_w(MAX_W'(SrcA), XLEN, a_sgn));
  assign b_mag  = XLEN'(abs_w(MAX_W'(SrcB), XLEN, b_sgn));

  assign div0    = is_div & (SrcB == '0);
  assign ovf     = is_div & ~MDUControl[0] & (SrcA == {1'b1, {(XLEN-1){1'b0}}}) & (SrcB == '1);
  assign special = div0 | ovf;
  // Overflow DIV returns the dividend itself (the most-negative value).
  assign spec_res = div0 ? (MDUControl[1] ? SrcA : '1) : (MDUControl[1] ? '0 : SrcA);
  assign accept   = in_valid & in_ready;

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = special ? DONE : CALC;
      end
      CALC: if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- one iteration step ----
  // Multiply: hi accumulates the addend (b_q) when the multiplier LSB (lo[0]) is set.
  // Divide:   restoring step, quotient bits shift into lo as the dividend shifts out.
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
    if (op_q[2]) begin
      hi_n = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---- sign fix-up ----
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = PW'(neg_if(MAX_W'({hi_q, lo_q}), neg_q));
    quo_fix  = XLEN'(neg_if(MAX_W'(lo_q), neg_q));
    rem_fix  = XLEN'(neg_if(MAX_W'(hi_q), neg_q));
    case ({op_q[2], op_q[1]})
      2'b10:   fix_res = quo_fix;
      2'b11:   fix_res = rem_fix;
      default: fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q  <= OP_MUL;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= op_in;
          cnt_q <= '0;
          hi_q  <= '0;
          // Remainder follows the dividend's sign; everything else follows sign XOR.
          neg_q <= (is_div & MDUControl[1]) ? a_neg : (a_neg ^ b_neg);
          b_q   <= is_div ? b_mag : a_mag;
          lo_q  <= is_div ? a_mag : b_mag;
          if (special) res_q <= spec_res;
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          hi_q  <= hi_n;
          lo_q  <= lo_n;
        end
        FIX:     res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign MDUResult = res_q;
  assign zero      = out_valid & (res_q == '0);

endmodule

// File: tb/tb_mdu_alu.sv
// Bench for mdu_alu: vector table, randomized ops against an arithmetic model,
// plus backpressure, mid-operation reset and an 8-bit instance.
module tb_mdu_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, z32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  op32;
  logic        iv8, ir8, ov8, or8, z8;
  logic [7:0]  a8, b8, r8;
  logic [2:0]  op8;

  mdu_alu #(.XLEN(32)) d32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32), .SrcA(a32), .SrcB(b32),
    .MDUControl(op32), .out_valid(ov32), .out_ready(or32), .MDUResult(r32), .zero(z32));

  mdu_alu #(.XLEN(8)) d8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .SrcA(a8), .SrcB(b8),
    .MDUControl(op8), .out_valid(ov8), .out_ready(or8), .MDUResult(r8), .zero(z8));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural special cases.
  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op while idle (called #1 after an edge), wait for the result, drain it.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat);
    op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
    lat = 1;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!ov32) lat = -1;
    res = r32; z = z32;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check("drain_valid", 64'(ov32), 64'd0);
    check("drain_ready", 64'(ir32), 64'd1);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] res, output int lat);
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!ov8) lat = -1;
    res = r8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic        expz;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] res;
    logic [7:0]  res8;
    logic        z;
    int          lat;
    logic        seen;

    tbl[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         1'b0, 34};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          1'b1, 34};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 34};
    tbl[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
    tbl[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
    tbl[5]  = '{3'd5, 32'h11,         32'h0,          32'hFFFF_FFFF,  1'b0, 1};
    tbl[6]  = '{3'd7, 32'h11,         32'h0,          32'h11,         1'b0, 1};
    tbl[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1};
    tbl[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b1, 1};
    tbl[9]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
    tbl[10] = '{3'd4, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b0, 1};
    tbl[11] = '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 34};

    reset_n = 1'b0;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; op32 = 0;
    iv8 = 0;  or8 = 0;  a8 = 0;  b8 = 0;  op8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ir32), 64'd1);
    check("rst_valid", 64'(ov32), 64'd0);
    check("rst_zero",  64'(z32),  64'd0);
    check("rst_result", 64'(r32), 64'd0);
    check("rst_ready8", 64'(ir8), 64'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run32(tbl[i].op, tbl[i].a, tbl[i].b, res, z, lat);
      check($sformatf("vec%0d_res", i), 64'(res), 64'(tbl[i].exp));
      check($sformatf("vec%0d_zero", i), 64'(z), 64'(tbl[i].expz));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
    end

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run32(op, a, b, res, z, lat);
      check($sformatf("rnd%0d_op%0d_res", i, op), 64'(res), 64'(model32(op, a, b)));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(lat32(op, a, b)));
    end

    // Backpressure; in_valid held high throughout must be ignored while busy.
    op32 = 3'd0; a32 = 32'd7; b32 = 32'd6; iv32 = 1'b1;
    @(posedge clk); #1;
    op32 = 3'd5; a32 = 32'd100; b32 = 32'd3;
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("bp_reach_valid", 64'(ov32), 64'd1);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_res", c), 64'(r32), 64'd42);
      check($sformatf("bp%0d_valid", c), 64'(ov32), 64'd1);
      check($sformatf("bp%0d_ready", c), 64'(ir32), 64'd0);
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check("bp_release_valid", 64'(ov32), 64'd0);
    check("bp_release_ready", 64'(ir32), 64'd1);

    // Reset mid-CALC: no result may ever appear.
    op32 = 3'd5; a32 = 32'd1000; b32 = 32'd7; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_ready", 64'(ir32), 64'd1);
    check("midrst_valid", 64'(ov32), 64'd0);
    check("midrst_result", 64'(r32), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ov32) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    run32(3'd5, 32'd1000, 32'd7, res, z, lat);
    check("postrst_res", 64'(res), 64'd142);

    // 8-bit instance.
    run8(3'd3, 8'hFF, 8'hFF, res8, lat);
    check("x8_mulhu_res", 64'(res8), 64'hFE);
    check("x8_mulhu_lat", 64'(lat), 64'd10);
    run8(3'd5, 8'd200, 8'd7, res8, lat);
    check("x8_divu_res", 64'(res8), 64'd28);
    run8(3'd4, 8'h80, 8'hFF, res8, lat);
    check("x8_ovf_res", 64'(res8), 64'h80);
    check("x8_ovf_lat", 64'(lat), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_alu.md
MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8, 16, 32, 64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port SrcA  input  XLEN  operand A (multiplicand/dividend).
REQ-007 SHALL have port SrcB  input  XLEN  operand B (multiplier/divisor).
REQ-008 SHALL have port MDUControl  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (RV32M funct3 encoding).
REQ-009 SHALL have port out_valid  output  1  MDUResult valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port MDUResult  output  XLEN  result.
REQ-012 SHALL have port zero  output  1  high when MDUResult == 0 and out_valid high; otherwise low.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; accept occurs on an edge with in_valid & in_ready.
REQ-015 SHALL capture SrcA, SrcB, MDUControl at accept; later input changes have no effect.
REQ-016 SHALL, for normal ops, go IDLE->CALC on accept, stay in CALC exactly XLEN cycles (one quotient/partial-product bit per cycle), then go CALC->FIX for 1 cycle, then FIX->DONE.
REQ-017 SHALL raise out_valid XLEN+2 cycles after the accept edge for normal ops.
REQ-018 SHALL, for special cases, go IDLE->DONE directly (out_valid 1 cycle after accept): divisor zero or signed overflow (DIV/REM, SrcA = most-negative, SrcB = -1).
REQ-019 SHALL return, for divide by zero: DIV/DIVU quotient all-ones; REM/REMU the dividend unchanged.
REQ-020 SHALL return, for signed overflow: DIV the most-negative value; REM 0.
REQ-021 SHALL compute signed ops on magnitudes (unsigned shift-add multiply to 2*XLEN bits, restoring divide) and apply sign correction in FIX: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-022 SHALL treat MULHSU as A signed, B unsigned; MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
REQ-023 SHALL hold MDUResult and out_valid stable in DONE while out_ready is low (backpressure, unbounded).
REQ-024 SHALL go DONE->IDLE on an edge with out_ready high; out_valid low in the next cycle; no new accept in the same cycle as completion.
REQ-025 SHALL ignore in_valid while not in IDLE.

Reset
REQ-026 SHALL, on an edge with reset_n low, enter IDLE with out_valid = 0, zero = 0, MDUResult = 0, in_ready = 1 from the next cycle; all datapath registers cleared.
REQ-027 SHALL abort an in-flight operation on reset in any state (CALC/FIX/DONE), discard the result and produce no out_valid pulse.

Structure
REQ-028 SHALL place the op enum (mdu_op_t), FSM state enum (mdu_state_t) and a parametrisable two's-complement negate/abs function in shared package mdu_pkg.
REQ-029 SHALL be a single module with no sub-module; FSM, counter (clog2(XLEN)+1 bits) and datapath are in mdu_alu; target is 150-300 lines.

Verification
REQ-030 SHALL verify MUL: SrcA = 7, SrcB = 6 -> MDUResult = 42, zero = 0, out_valid exactly 34 cycles after accept (XLEN = 32).
REQ-031 SHALL verify MULH: SrcA = SrcB = 0xFFFFFFFF -> 0x00000000, zero = 1; MULHU with the same operands -> 0xFFFFFFFE.
REQ-032 SHALL verify DIV: -7 / 2 -> 0xFFFFFFFD (-3); REM: -7 % 2 -> 0xFFFFFFFF (-1).
REQ-033 SHALL verify DIVU: 0x11 / 0 -> 0xFFFFFFFF after 1 cycle; REMU: 0x11 % 0 -> 0x11; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0, zero = 1.
REQ-034 SHALL verify backpressure and reset: out_ready held low 10 cycles -> result stable and in_ready = 0; reset_n low mid-CALC -> out_valid stays 0 and in_ready = 1 next cycle.
REQ-035 SHALL verify XLEN = 8 instance: MULHU 0xFF * 0xFF -> 0xFE, out_valid 10 cycles after accept.
